// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver, oversampled in clk, with a show-ahead stereo FIFO.
// Define I2S_RX_PEAK_EN to add per-channel peak magnitude meters.
module i2s_rx #(
  parameter int WIDTH   = 16,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2s_bclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_data,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
`ifdef I2S_RX_PEAK_EN
  input  logic             peak_clr,
  output logic [WIDTH-2:0] peak_l,
  output logic [WIDTH-2:0] peak_r,
`endif
  output logic [3:0]       dbg
);
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RX_L = 2'd1,
    RX_R = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       bclk_s;
  logic [1:0]       lr_s;
  logic [1:0]       dat_s;
  logic             strobe, ws, bit_s, ws_d, word_end;
  logic [WIDTH-1:0] sreg, sreg_nx, word;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             latch_l, latch_r;
  logic [WIDTH-1:0] left_q, right_q;
  logic             push_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s <= '0;
      lr_s   <= '0;
      dat_s  <= '0;
    end else begin
      bclk_s <= {bclk_s[1:0], i2s_bclk};
      lr_s   <= {lr_s[0], i2s_lrclk};
      dat_s  <= {dat_s[0], i2s_data};
    end
  end

  assign strobe   = bclk_s[1] & ~bclk_s[2];
  assign ws       = lr_s[1];
  assign bit_s    = dat_s[1];
  assign word_end = ws ^ ws_d;

  // Bits past WIDTH are dropped; short words are left-justified.
  always_comb begin
    sreg_nx = sreg;
    cnt_nx  = cnt;
    if (cnt < CW'(WIDTH)) begin
      sreg_nx = {sreg[WIDTH-2:0], bit_s};
      cnt_nx  = cnt + CW'(1);
    end
    word = sreg_nx << (CW'(WIDTH) - cnt_nx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_d <= 1'b0;
      sreg <= '0;
      cnt  <= '0;
    end else if (strobe) begin
      ws_d <= ws;
      if (word_end) begin
        sreg <= '0;
        cnt  <= '0;
      end else begin
        sreg <= sreg_nx;
        cnt  <= cnt_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (strobe && word_end) begin
      unique case (state_q)
        HUNT:    if (!ws) state_d = RX_L;
        RX_L:    if (ws)  state_d = RX_R;
        RX_R:    if (!ws) state_d = RX_L;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    latch_l = 1'b0;
    latch_r = 1'b0;
    if (strobe && word_end) begin
      unique case (1'b1)
        (state_q == RX_L): latch_l = ws;
        (state_q == RX_R): latch_r = !ws;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
      push_q  <= 1'b0;
    end else begin
      push_q <= latch_r;
      if (latch_l) left_q  <= word;
      if (latch_r) right_q <= word;
    end
  end

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head;
  logic [FIFO_AW:0]   wptr, rptr;
  logic               full, pop, wr_en;

  assign full = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign out_valid = (wptr != rptr);
  assign pop   = out_valid & out_ready;
  assign wr_en = push_q & (~full | pop);
  assign head  = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[FIFO_AW-1:0]] <= {left_q, right_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (push_q && !wr_en) overflow <= 1'b1;
    end
  end

  assign out_left  = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign out_right = out_valid ? head[WIDTH-1:0] : '0;
  assign dbg       = {state_q, full, overflow};

`ifdef I2S_RX_PEAK_EN
  function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = -s;
    if (!s[WIDTH-1])   return s[WIDTH-2:0];
    if (n[WIDTH-1])    return '1;
    return n[WIDTH-2:0];
  endfunction

  logic [WIDTH-2:0] mag_l, mag_r;
  assign mag_l = mag(left_q);
  assign mag_r = mag(right_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (peak_clr) begin
      peak_l <= wr_en ? mag_l : '0;
      peak_r <= wr_en ? mag_r : '0;
    end else if (wr_en) begin
      if (mag_l > peak_l) peak_l <= mag_l;
      if (mag_r > peak_r) peak_r <= mag_r;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S streams checked against a frame-level model.
// Peak checks are compiled only with I2S_RX_PEAK_EN.
module tb_i2s_rx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, bclk, lrclk, data, out_ready;
  logic [W-1:0] out_left, out_right;
  logic         out_valid, overflow;
  logic [3:0]   dbg;
`ifdef I2S_RX_PEAK_EN
  logic         peak_clr;
  logic [W-2:0] peak_l, peak_r;
  logic [W-2:0] obs_pk_l, obs_pk_r;
`endif

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(W), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data),
    .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow),
`ifdef I2S_RX_PEAK_EN
    .peak_clr(peak_clr), .peak_l(peak_l), .peak_r(peak_r),
`endif
    .dbg(dbg)
  );

  typedef struct packed {
    logic [5:0]  n;
    logic [31:0] v;
  } word_t;

  int n_vec = 0;
  int n_fail = 0;
  int rdy_mode;
  int rst_at;
  bit pulse_pop, pulse_clr;
  logic obs_valid [1:4];
  word_t words[$];
  logic [2*W-1:0] got[$];
  logic [2*W-1:0] exp_q[$];

  function automatic logic [31:0] mask(input logic [31:0] v, input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return v & m[31:0];
  endfunction

  // A slot keeps its W most significant bits, or is zero padded on the right.
  function automatic logic [W-1:0] align(input word_t w);
    logic [63:0] x;
    x = {32'd0, w.v};
    if (int'(w.n) >= W) x = x >> (int'(w.n) - W);
    else                x = x << (W - int'(w.n));
    return x[W-1:0];
  endfunction

  task automatic add_frame(input int nl, input logic [31:0] l,
                           input int nr, input logic [31:0] r,
                           input bit keep);
    word_t a, b;
    a.n = 6'(nl);
    a.v = mask(l, nl);
    b.n = 6'(nr);
    b.v = mask(r, nr);
    words.push_back(a);
    words.push_back(b);
    if (keep) exp_q.push_back({align(a), align(b)});
  endtask

  task automatic consume(input bit force1);
    bit r;
    case (rdy_mode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      default: r = ($urandom_range(0, 1) == 1);
    endcase
    if (force1) r = 1'b1;
    if (out_valid && r) got.push_back({out_left, out_right});
    out_ready = r;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      consume(1'b0);
    end
  endtask

  // Drives the queued words; LRCLK leads data by one bit period.
  task automatic send();
    bit wsq[$];
    bit bq[$];
    bit last;
    foreach (words[i])
      for (int b = int'(words[i].n) - 1; b >= 0; b--) begin
        wsq.push_back(i % 2 == 1);
        bq.push_back(words[i].v[b]);
      end
    for (int k = 0; k <= wsq.size(); k++) begin
      last  = (k == wsq.size());
      bclk  = 1'b0;
      lrclk = (k < wsq.size()) ? wsq[k] : 1'b0;
      data  = (k > 0) ? bq[k-1] : 1'b0;
      if (k == rst_at) rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (i == 2) rst = 1'b0;
        consume(1'b0);
      end
      bclk = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (last) obs_valid[i] = out_valid;
`ifdef I2S_RX_PEAK_EN
        if (last && i == 3) begin
          obs_pk_l = peak_l;
          obs_pk_r = peak_r;
        end
        peak_clr = pulse_clr && last && (i == 3);
`endif
        consume(pulse_pop && last && (i == 3));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b0;
    data = 1'b0;
    out_ready = 1'b0;
    rdy_mode = 0;
    rst_at = -1;
    pulse_pop = 1'b0;
    pulse_clr = 1'b0;
`ifdef I2S_RX_PEAK_EN
    peak_clr = 1'b0;
`endif
    words.delete();
    exp_q.delete();
    got.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if ({out_left, out_right} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {out_left, out_right});
    end
    n_vec++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", overflow);
    end
    n_vec++;
    if (dbg !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_dbg: got %h want 0", dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    add_frame(16, 32'h1234, 16, 32'hABCD, 1'b1);
    send();
    n_vec++;
    if (obs_valid[3] !== 1'b0 || obs_valid[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got %b%b want 01", obs_valid[3], obs_valid[4]);
    end
    rdy_mode = 1;
    drain(10);
    n_vec++;
    if (got.size() != 1 || got[0] !== 32'h1234ABCD) begin
      n_fail++;
      $display("FAIL basic_frame: got %0d frames head %h want 1 frame 1234abcd",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_slot_width();
    do_reset();
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    add_frame(24, 32'h89ABCD, 8, 32'h5A, 1'b1);
    add_frame(8, 32'h5A, 24, 32'h89ABCD, 1'b1);
    rdy_mode = 1;
    send();
    drain(10);
    n_vec++;
    if (got.size() != 2 || got[0] !== 32'h89AB5A00 || got[1] !== 32'h5A0089AB) begin
      n_fail++;
      $display("FAIL slot_const: got %0d frames %h %h want 89ab5a00 5a0089ab",
               got.size(), (got.size() > 0) ? got[0] : 32'hx,
               (got.size() > 1) ? got[1] : 32'hx);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    repeat (5) add_frame(16, $urandom, 16, $urandom, 1'b1);
    send();
    n_vec++;
    if (overflow !== 1'b1 || dbg[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL ovf_flag: got ovf=%b dbg=%h want ovf=1 full=1", overflow, dbg);
    end
    rdy_mode = 1;
    drain(20);
    n_vec++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_frame%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
      end
    end
    n_vec++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    repeat (5) add_frame(16, $urandom, 16, $urandom, 1'b1);
    pulse_pop = 1'b1;
    send();
    n_vec++;
    if (overflow !== 1'b0 || dbg[1] !== 1'b1 || got.size() != 1) begin
      n_fail++;
      $display("FAIL fullpop_state: got ovf=%b full=%b popped=%0d want 0 1 1",
               overflow, dbg[1], got.size());
    end
    rdy_mode = 1;
    drain(20);
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fullpop_frame%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_resync();
    do_reset();
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    add_frame(16, $urandom, 16, $urandom, 1'b1);
    add_frame(16, $urandom, 16, $urandom, 1'b1);
    rst_at = 56;
    rdy_mode = 1;
    send();
    drain(10);
    n_vec++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL resync_count: got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL resync_frame%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rdy_mode = 2;
      add_frame($urandom_range(4, 32), $urandom, $urandom_range(4, 32), $urandom, 1'b0);
      repeat ($urandom_range(1, 4))
        add_frame($urandom_range(4, 32), $urandom,
                  $urandom_range(4, 32), $urandom, 1'b1);
      send();
      drain(60);
      n_vec++;
      if (got.size() != exp_q.size() || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d ovf=%b want %0d ovf=0",
                 r, got.size(), overflow, exp_q.size());
      end
      foreach (exp_q[i]) begin
        n_vec++;
        if (i >= got.size() || got[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_frame%0d: got %h want %h", r, i,
                   (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
        end
      end
    end
  endtask

`ifdef I2S_RX_PEAK_EN
  task automatic test_peak();
    do_reset();
    add_frame(16, $urandom, 16, $urandom, 1'b0);
    add_frame(16, 32'h8000, 16, 32'd100, 1'b1);
    add_frame(16, 32'd5, 16, 32'd0, 1'b1);
    pulse_clr = 1'b1;
    rdy_mode = 1;
    send();
    drain(4);
    n_vec++;
    if (obs_pk_l !== 15'd32767 || obs_pk_r !== 15'd100) begin
      n_fail++;
      $display("FAIL peak_max: got %0d/%0d want 32767/100", obs_pk_l, obs_pk_r);
    end
    n_vec++;
    if (peak_l !== 15'd5 || peak_r !== 15'd0) begin
      n_fail++;
      $display("FAIL peak_clr: got %0d/%0d want 5/0", peak_l, peak_r);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_slot_width();
    test_overflow();
    test_full_pop();
    test_resync();
    test_random();
`ifdef I2S_RX_PEAK_EN
    test_peak();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
